// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, register indices and fetch descriptor type
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int REG_AW = 4;
    localparam int OP_W   = 5;

    localparam logic [REG_AW-1:0] REG_X  = 4'd0;
    localparam logic [REG_AW-1:0] REG_Y  = 4'd1;
    localparam logic [REG_AW-1:0] REG_Z  = 4'd2;
    localparam logic [REG_AW-1:0] REG_W  = 4'd3;
    localparam logic [REG_AW-1:0] REG_R0 = 4'd4;
    localparam logic [REG_AW-1:0] REG_R1 = 4'd5;
    localparam logic [REG_AW-1:0] REG_R2 = 4'd6;
    localparam logic [REG_AW-1:0] REG_R3 = 4'd7;
    localparam logic [REG_AW-1:0] REG_R4 = 4'd8;
    localparam logic [REG_AW-1:0] REG_R5 = 4'd9;
    localparam logic [REG_AW-1:0] REG_R6 = 4'd10;
    localparam logic [REG_AW-1:0] REG_R7 = 4'd11;
    localparam logic [REG_AW-1:0] REG_A  = 4'd12;
    localparam logic [REG_AW-1:0] REG_B  = 4'd13;
    localparam logic [REG_AW-1:0] REG_C  = 4'd14;
    localparam logic [REG_AW-1:0] REG_M  = 4'd15;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic [OP_W-1:0]   op;
    } fetch_desc_t;

    function automatic logic addr_hit(input logic en, input logic [REG_AW-1:0] a,
                                      input logic [REG_AW-1:0] b);
        return en && (a == b);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// rtl/operand_bypass.sv - forwarding mux for one source operand
module operand_bypass
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              wbq_en,
    input  logic [REG_AW-1:0] wbq_addr,
    input  logic [DATA_W-1:0] wbq_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] pend_val,
    output logic [DATA_W-1:0] move_val
);

    // pend_val: contents as of the last edge; move_val also folds in this edge's write
    always_comb begin
        pend_val = addr_hit(wbq_en, wbq_addr, rs) ? wbq_data : rf_rdata;
        move_val = addr_hit(wb_en, wb_addr, rs) ? wb_data : pend_val;
    end

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand fetch stage with write-back forwarding
module operand_fetch
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_wr,
    input  logic [OP_W-1:0]   in_op,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_wr,
    output logic [OP_W-1:0]   out_op
);

    fetch_desc_t       in_desc, pend_desc, out_desc;
    logic              pend_valid;
    logic              wbq_en;
    logic [REG_AW-1:0] wbq_addr;
    logic [DATA_W-1:0] wbq_data;
    logic [REG_AW-1:0] raddr1_q, raddr2_q;
    logic              out_free, accept, move, hold;
    logic [DATA_W-1:0] pend_a, pend_b, move_a, move_b;

    assign in_desc  = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, wr: in_wr, op: in_op};
    assign out_free = !out_valid || out_ready;
    assign in_ready = !pend_valid || out_free;
    assign accept   = in_valid && in_ready;
    assign move     = pend_valid && out_free;
    assign hold     = out_valid && !out_ready;

    // A stalled PEND keeps re-reading its sources so rf_rdata stays current
    always_comb begin
        rf_raddr1 = raddr1_q;
        rf_raddr2 = raddr2_q;
        if (accept) begin
            rf_raddr1 = in_rs1;
            rf_raddr2 = in_rs2;
        end else if (pend_valid) begin
            rf_raddr1 = pend_desc.rs1;
            rf_raddr2 = pend_desc.rs2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            raddr1_q <= '0;
            raddr2_q <= '0;
            wbq_en   <= 1'b0;
            wbq_addr <= '0;
            wbq_data <= '0;
        end else begin
            raddr1_q <= rf_raddr1;
            raddr2_q <= rf_raddr2;
            wbq_en   <= wb_en;
            wbq_addr <= wb_addr;
            wbq_data <= wb_data;
        end
    end

    operand_bypass u_bypass_a (
        .rs       (pend_desc.rs1),
        .rf_rdata (rf_rdata1),
        .wbq_en   (wbq_en),
        .wbq_addr (wbq_addr),
        .wbq_data (wbq_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .pend_val (pend_a),
        .move_val (move_a)
    );

    operand_bypass u_bypass_b (
        .rs       (pend_desc.rs2),
        .rf_rdata (rf_rdata2),
        .wbq_en   (wbq_en),
        .wbq_addr (wbq_addr),
        .wbq_data (wbq_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .pend_val (pend_b),
        .move_val (move_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_desc  <= '0;
        end else begin
            if (accept)
                pend_desc <= in_desc;
            if (flush)
                pend_valid <= 1'b0;
            else if (accept)
                pend_valid <= 1'b1;
            else if (move)
                pend_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_desc  <= '0;
            out_a     <= '0;
            out_b     <= '0;
        end else begin
            if (flush)
                out_valid <= 1'b0;
            else if (out_free)
                out_valid <= pend_valid;
            if (move) begin
                out_desc <= pend_desc;
                out_a    <= move_a;
                out_b    <= move_b;
            end else if (hold) begin
                // Snoop write-back while the consumer is stalled
                if (addr_hit(wb_en, wb_addr, out_desc.rs1))
                    out_a <= wb_data;
                if (addr_hit(wb_en, wb_addr, out_desc.rs2))
                    out_b <= wb_data;
            end
        end
    end

    assign out_rd = out_desc.rd;
    assign out_wr = out_desc.wr;
    assign out_op = out_desc.op;

    logic unused_pend;
    assign unused_pend = ^{pend_a, pend_b};

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - randomized scoreboard bench for operand_fetch
module tb_operand_fetch;
    import cpu_pkg::*;

    logic       clk = 1'b0, reset = 1'b1, flush = 1'b0;
    logic       in_valid = 1'b0, in_wr = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
    logic [3:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_addr = '0;
    logic [4:0] in_op = '0;
    logic [7:0] wb_data = '0;
    logic       in_ready, out_valid, out_wr;
    logic [3:0] rf_raddr1, rf_raddr2, out_rd;
    logic [7:0] rf_rdata1, rf_rdata2, out_a, out_b;
    logic [4:0] out_op;

    logic [7:0] regs [16];

    typedef struct {
        logic [3:0] rs1, rs2, rd;
        logic       wr;
        logic [4:0] op;
        int         t;
    } exp_t;
    exp_t q[$];

    int cyc = 0, n_tests = 0, n_fail = 0, thr_cnt = 0;

    operand_fetch dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr(in_wr), .in_op(in_op),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_wr(out_wr), .out_op(out_op)
    );

    always #5 clk = ~clk;

    // Register file: registered read, read-before-write
    always @(posedge clk) begin
        rf_rdata1 <= regs[rf_raddr1];
        rf_rdata2 <= regs[rf_raddr2];
        if (wb_en) regs[wb_addr] <= wb_data;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom % 2 == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    endfunction

    // Oldest descriptor becomes visible two edges after its accept; operands track the regfile
    task automatic check_out();
        logic ev;
        ev = (q.size() > 0) && (cyc - q[0].t >= 2);
        check_eq("out_valid", 32'(out_valid), 32'(ev));
        if (ev && out_valid) begin
            check_eq("out_rd", 32'(out_rd), 32'(q[0].rd));
            check_eq("out_wr", 32'(out_wr), 32'(q[0].wr));
            check_eq("out_op", 32'(out_op), 32'(q[0].op));
            check_eq("out_a", 32'(out_a), 32'(regs[q[0].rs1]));
            check_eq("out_b", 32'(out_b), 32'(regs[q[0].rs2]));
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] r1, input logic [3:0] r2,
                        input logic [3:0] rd, input logic w, input logic [4:0] op,
                        input logic ordy, input logic we, input logic [3:0] wa,
                        input logic [7:0] wd, input logic fl);
        logic acc, hs;
        in_valid = iv; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_wr = w; in_op = op;
        out_ready = ordy; wb_en = we; wb_addr = wa; wb_data = wd; flush = fl;
        #1;
        check_eq("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
        acc = iv && in_ready;
        hs  = out_valid && ordy;
        if (acc) begin
            check_eq("raddr1", 32'(rf_raddr1), 32'(r1));
            check_eq("raddr2", 32'(rf_raddr2), 32'(r2));
        end
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (hs && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back('{r1, r2, rd, w, op, cyc});
        end
        cyc++;
        @(negedge clk);
        check_out();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0, ordy, 1'b0, 4'd0, 8'd0, 1'b0);
    endtask

    task automatic rnd_step(input logic ordy, input logic iv, input logic fl);
        step(iv, rnd_reg(), rnd_reg(), 4'($urandom), 1'($urandom), 5'($urandom),
             ordy, 1'($urandom), rnd_reg(), 8'($urandom), fl);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_a", 32'(out_a), 32'd0);
        check_eq("rst_out_b", 32'(out_b), 32'd0);
        check_eq("rst_out_rd", 32'(out_rd), 32'd0);
        check_eq("rst_out_wr", 32'(out_wr), 32'd0);
        check_eq("rst_out_op", 32'(out_op), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_raddr1", 32'(rf_raddr1), 32'd0);
        check_eq("rst_raddr2", 32'(rf_raddr2), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b1, 1'b1, 4'(i),
                 (i == 1) ? 8'h11 : (i == 2) ? 8'h22 : 8'($urandom), 1'b0);

        step(1'b1, REG_Y, REG_Z, REG_W, 1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq("pre_a", 32'(out_a), 32'h11);
        check_eq("pre_b", 32'(out_b), 32'h22);
        check_eq("pre_rd", 32'(out_rd), 32'd3);
        idle(1'b1);

        step(1'b1, REG_R0, REG_Y, REG_R1, 1'b0, 5'd1, 1'b1, 1'b1, REG_R0, 8'h5A, 1'b0);
        idle(1'b1);
        check_eq("raw_a", 32'(out_a), 32'h5A);
        idle(1'b1);

        step(1'b1, REG_X, REG_A, REG_R2, 1'b1, 5'd2, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        step(1'b1, REG_A, REG_B, REG_R3, 1'b1, 5'd3, 1'b0, 1'b0, 4'd0, 8'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 5'd0, 1'b0, 1'b1, REG_A, 8'h7E, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check_eq("stall_b", 32'(out_b), 32'h7E);
        idle(1'b1);
        check_eq("stall_pend_a", 32'(out_a), 32'h7E);
        idle(1'b1);

        step(1'b1, REG_M, REG_M, REG_R4, 1'b0, 5'd4, 1'b1, 1'b1, REG_M, 8'hC3, 1'b0);
        idle(1'b1);
        check_eq("same_a", 32'(out_a), 32'hC3);
        check_eq("same_b", 32'(out_b), 32'hC3);
        idle(1'b1);

        for (int k = 0; k < 10; k++) begin
            rnd_step(1'b1, k < 8, 1'b0);
            if (out_valid) thr_cnt++;
        end
        check_eq("throughput", 32'(thr_cnt), 32'd8);

        rnd_step(1'b0, 1'b1, 1'b0);
        rnd_step(1'b0, 1'b1, 1'b0);
        rnd_step(1'b0, 1'b1, 1'b0);
        rnd_step(1'b0, 1'b1, 1'b1);
        check_eq("flush_ov", 32'(out_valid), 32'd0);
        idle(1'b1);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
                #2 reset = 1'b1;
                #1;
                check_eq("arst_out_valid", 32'(out_valid), 32'd0);
                check_eq("arst_out_a", 32'(out_a), 32'd0);
                check_eq("arst_out_b", 32'(out_b), 32'd0);
                check_eq("arst_out_rd", 32'(out_rd), 32'd0);
                check_eq("arst_in_ready", 32'(in_ready), 32'd1);
                @(negedge clk);
                reset = 1'b0;
                q.delete();
            end
            rnd_step(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 60) == 0);
        end

        repeat (4) idle(1'b1);
        check_eq("drain", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch pipeline stage between instruction decode and the ALU. It accepts decoded register descriptors over a valid/ready handshake and drives read addresses to the 16×8 register file, which has registered (1-cycle) read outputs. It forwards write-back data around the register file's read-before-write behaviour. It presents the descriptor plus both 8-bit operands to the execute stage over a second valid/ready handshake, at full throughput.

## Interface
- DATA_W, 8, operand width
- REG_AW, 4, register address width (16 registers: X,Y,Z,W,r0–r7,A,B,C,M at indices 0–15)
- OP_W, 5, opaque opcode/control field passed through unchanged
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous; drops all in-flight descriptors
- in_valid / in_ready  in / out  1 / 1  upstream handshake
- in_rs1, in_rs2, in_rd  in  REG_AW each  source and destination indices
- in_wr  in  1  descriptor writes back
- in_op  in  OP_W  passthrough
- rf_raddr1, rf_raddr2  out  REG_AW each  register-file read addresses (combinational)
- rf_rdata1, rf_rdata2  in  DATA_W each  register-file read data; reflects the address driven in the previous cycle and the register state before that edge's write
- wb_en, wb_addr, wb_data  in  1, REG_AW, DATA_W  the same write-back bus that drives the register file
- out_valid / out_ready  out / in  1 / 1  downstream handshake
- out_a, out_b  out  DATA_W each  operand values of rs1 and rs2
- out_rd, out_wr, out_op  out  REG_AW, 1, OP_W  passthrough

## Operation
- Two internal slots:
  - PEND holds a descriptor whose read was issued last cycle.
  - OUT is the output register.
- Each slot has a valid bit. The stage is idle, busy, or stalled depending on these bits.
- out_free = !out_valid || out_ready.
- in_ready = !pend_valid || out_free. Accept means in_valid && in_ready.
- Read address selection:
  - rf_raddr = in_rs* when accepting.
  - Otherwise rf_raddr = pend_rs*. A stalled PEND therefore re-reads each cycle and sees fresh values.
  - With no accept and no PEND, the addresses are don't-care but stable.
- Write-back capture: the wb bus is registered every cycle into WBQ (en, addr, data).
- PEND operand value, per source: if wbq_en && wbq_addr == rs, use wbq_data; otherwise use rf_rdata. This fixes the register file returning the pre-write value.
- PEND→OUT move, when pend_valid && out_free: OUT loads the descriptor with the PEND operand value. A wb on that same edge that matches rs has priority and loads wb_data.
- OUT hold, when out_valid && !out_ready: on each edge where wb_en && wb_addr matches out_rs1 or out_rs2, the matching operand is replaced with wb_data.
- Net rule: presented operands always equal the register contents including every write up to the current cycle's preceding edge.
- Both sources may name the same register; forwarding then applies to both. A write to the descriptor's own rd is not special.
- flush: pend_valid and out_valid clear at the next edge, and an accept in that cycle is discarded. WBQ is unaffected.

## Timing
- Latency: accept at edge E0 → out_valid high after E1, so operands are visible 2 cycles after accept. Throughput is 1 per cycle with out_ready held high.
- out_valid stays high and all out_* stay stable (except wb snooping of out_a/out_b) until out_ready is sampled high.
- Reset values:
  - out_valid = 0; out_a, out_b, out_rd, out_op = 0; out_wr = 0.
  - in_ready = 1 immediately after reset deasserts.
  - pend_valid = 0; WBQ cleared.
  - rf_raddr = 0.
- Reset mid-operation discards all descriptors with no partial output.
- Full stall: with both slots valid and out_ready low, in_ready is low. When out_ready rises, PEND→OUT and a new accept both happen on the same edge.

## Structure
- Shared package cpu_pkg:
  - DATA_W, REG_AW, OP_W
  - Register index constants REG_X … REG_M
  - typedef fetch_desc_t {rs1, rs2, rd, wr, op}
- Sub-module operand_bypass: combinational selection of (wb, wbq, rf_rdata) for one source, instantiated twice.

## Test plan
- Reset preload: regfile rY=0x11, rZ=0x22. Issue rs1=Y, rs2=Z, rd=W → after 2 cycles, out_a=0x11, out_b=0x22, out_rd=3.
- Back-to-back RAW: wb writes r0=0x5A on the edge that issues rs1=r0 → out_a=0x5A, not the stale value.
- Stall refresh: hold out_ready low 4 cycles while wb writes rA=0x7E, matching out_rs2 → out_b becomes 0x7E. A PEND reading rA also yields 0x7E once it moves.
- Same-source case: rs1=rs2=rM with a write of 0xC3 in flight → out_a = out_b = 0xC3.
- Throughput: 8 descriptors with out_ready=1 → 8 consecutive out_valid cycles in order. Random out_ready toggling → no loss or duplication.
- Flush/reset: assert flush with both slots full → out_valid=0 next cycle. Async reset mid-stream → out_valid=0 immediately and outputs zero.
